// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter sharing the memory port between icache fills and dcache fills/evictions.
// Optional build macro MEM_ARB_RR_EN: round-robin ties instead of dcache priority + starvation guard.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGntIc = 2'd1,
    StGntDc = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic w_tie_ic;
  logic w_grant_ic;
  logic w_grant_dc;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;

  // Grants are only decided in IDLE; w_tie_ic settles who wins when both ask.
  assign w_grant_ic = (r_state == StIdle) && ic_req && (!dc_req || w_tie_ic);
  assign w_grant_dc = (r_state == StIdle) && dc_req && (!ic_req || !w_tie_ic);

`ifdef MEM_ARB_RR_EN
  logic r_rr_ic;

  // Pointer names the requester that wins the next tie; it flips away from each grantee.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ic <= 1'b0;
    end else if (w_grant_ic) begin
      r_rr_ic <= 1'b0;
    end else if (w_grant_dc) begin
      r_rr_ic <= 1'b1;
    end
  end

  assign w_tie_ic = r_rr_ic;
`else
  localparam int unsigned    CntW      = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] r_starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_grant_ic) begin
      r_starve_cnt <= '0;
    end else if (ic_req && (r_state != StGntIc) && (r_starve_cnt != StarveMax)) begin
      r_starve_cnt <= r_starve_cnt + CntW'(1);
    end
  end

  assign w_tie_ic = (r_starve_cnt == StarveMax);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_grant_ic) begin
          w_state_next = StGntIc;
        end else if (w_grant_dc) begin
          w_state_next = StGntDc;
        end
      end
      StGntIc, StGntDc: begin
        if (mem_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Request fields are frozen at grant so the memory side sees them stable for the whole beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant_ic) begin
      r_we    <= 1'b0;
      r_addr  <= ic_addr;
      r_wdata <= '0;
    end else if (w_grant_dc) begin
      r_we    <= dc_we;
      r_addr  <= dc_addr;
      r_wdata <= dc_wdata;
    end
  end

  always_comb begin
    busy      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ic_ready  = 1'b0;
    ic_rdata  = '0;
    dc_ready  = 1'b0;
    dc_rdata  = '0;
    case (r_state)
      StGntIc: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        ic_ready  = mem_ready;
        if (mem_ready) begin
          ic_rdata = mem_rdata;
        end
      end
      StGntDc: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        dc_ready  = mem_ready;
        if (mem_ready) begin
          dc_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // A requester that drops its request mid-transaction is still served; these only flag it.
  a_ic_hold: assert property (@(posedge clk) disable iff (rst) (r_state == StGntIc) |-> ic_req)
    else $error("ic_req dropped before ic_ready");

  a_dc_hold: assert property (@(posedge clk) disable iff (rst) (r_state == StGntDc) |-> dc_req)
    else $error("dc_req dropped before dc_ready");

  a_mem_stable: assert property (@(posedge clk) disable iff (rst)
    (mem_req && !mem_ready) |=> (mem_req && $stable(mem_we) && $stable(mem_addr)
                                 && $stable(mem_wdata)))
    else $error("memory request changed before mem_ready");

endmodule
